// File: rtl/cpu_reg_package.sv
// -----------------------------------------------------------------------------
// cpu_reg_package
// Shared CPU-side bus widths plus the types used by the bus master arbiter:
//   address_width / data_width : CPU bus address and data widths
//   arb_state_t                : arbiter FSM states
//   bus_req_t                  : one latched bus request (we, we_ram, address, data)
// -----------------------------------------------------------------------------
package cpu_reg_package;

    localparam int unsigned address_width = 32;
    localparam int unsigned data_width    = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                     we;
        logic [3:0]               we_ram;
        logic [address_width-1:0] address;
        logic [data_width-1:0]    data;
    } bus_req_t;

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin selection: returns the first requester at or after
// (last_grant_i + 1) modulo NumRequesters whose request bit is set.
//   req_i        : request vector
//   last_grant_i : index of the most recent grant
//   grant_o      : selected requester index (valid only with valid_o)
//   valid_o      : at least one request is pending
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned IdxW          = $clog2(NumRequesters)
) (
    input  logic [NumRequesters-1:0] req_i,
    input  logic [IdxW-1:0]          last_grant_i,
    output logic [IdxW-1:0]          grant_o,
    output logic                     valid_o
);

    int unsigned     idx;
    logic [IdxW-1:0] idx_w;
    logic            found;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        // Scan starting one past the last grant so the previous winner is
        // considered last.
        for (int unsigned i = 1; i <= NumRequesters; i++) begin
            idx   = (32'(last_grant_i) + i) % NumRequesters;
            idx_w = IdxW'(idx);
            if (!found && req_i[idx_w]) begin
                found   = 1'b1;
                grant_o = idx_w;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// -----------------------------------------------------------------------------
// bus_master_arbiter
// Round-robin arbiter letting NumRequesters masters share one CPU-side bus.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE.
//   clk_i, reset_ni        : clock, asynchronous active-low reset
//   req_i                  : per-requester request, held until ack_o
//   req_we_i/req_we_ram_i  : per-requester write enable / byte enables (flat)
//   req_address_i/req_data_i : per-requester address / write data (flat)
//   ack_o                  : one-hot, one-cycle completion pulse
//   error_o, rdata_o       : timeout flag and read data, valid with ack_o
//   bus_*_o                : shared bus drive (idle address / zeros when idle)
//   bus_data_i, bus_busy_i : read data and halt/busy from the bus
// -----------------------------------------------------------------------------
module bus_master_arbiter
    import cpu_reg_package::*;
#(
    parameter int unsigned              NumRequesters = 2,
    parameter int unsigned              TimeoutCycles = 1024,
    parameter logic [address_width-1:0] IdleAddress  = '1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_ni,
    input  logic [NumRequesters-1:0]                req_i,
    input  logic [NumRequesters-1:0]                req_we_i,
    input  logic [4*NumRequesters-1:0]              req_we_ram_i,
    input  logic [address_width*NumRequesters-1:0]  req_address_i,
    input  logic [data_width*NumRequesters-1:0]     req_data_i,
    output logic [NumRequesters-1:0]                ack_o,
    output logic                                    error_o,
    output logic [data_width-1:0]                   rdata_o,
    output logic                                    bus_we_o,
    output logic [3:0]                              bus_we_ram_o,
    output logic [address_width-1:0]                bus_address_o,
    output logic [data_width-1:0]                   bus_data_o,
    input  logic [data_width-1:0]                   bus_data_i,
    input  logic                                    bus_busy_i
);

    localparam int unsigned IdxW = $clog2(NumRequesters);
    localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
    localparam logic [CntW-1:0] CntMax      = '1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);

    arb_state_t            state_q, state_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       last_grant_q, last_grant_d;
    bus_req_t              req_q, req_d;
    logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [data_width-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    int unsigned           sel;

    rr_priority_picker #(
        .NumRequesters (NumRequesters),
        .IdxW          (IdxW)
    ) u_picker (
        .req_i        (req_i),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        wait_cnt_d   = wait_cnt_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        sel          = 32'(pick_idx);

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d        = pick_idx;
                    last_grant_d   = pick_idx;
                    req_d.we       = req_we_i[pick_idx];
                    req_d.we_ram   = req_we_ram_i[sel*4 +: 4];
                    req_d.address  = req_address_i[sel*address_width +: address_width];
                    req_d.data     = req_data_i[sel*data_width +: data_width];
                    state_d        = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (wait_cnt_q != CntMax) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                // The first WAIT cycle is never a capture point; the bus needs
                // one cycle to raise busy after seeing the address change.
                if (wait_cnt_q != '0 && !bus_busy_i) begin
                    rdata_d = bus_data_i;
                    error_d = 1'b0;
                    state_d = ARB_DONE;
                end else if (wait_cnt_q == TimeoutLast && bus_busy_i) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus_address_o = IdleAddress;
        bus_we_o      = 1'b0;
        bus_we_ram_o  = '0;
        bus_data_o    = '0;
        ack_o         = '0;
        rdata_o       = '0;
        error_o       = 1'b0;
        case (state_q)
            ARB_ISSUE: begin
                bus_address_o = req_q.address;
                bus_we_o      = req_q.we;
                bus_we_ram_o  = req_q.we_ram;
                bus_data_o    = req_q.data;
            end
            ARB_WAIT: bus_address_o = req_q.address;
            ARB_DONE: begin
                ack_o[grant_q] = 1'b1;
                rdata_o        = rdata_q;
                error_o        = error_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= IdxW'(NumRequesters - 1);
            req_q        <= '0;
            wait_cnt_q   <= '0;
            rdata_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            req_q        <= req_d;
            wait_cnt_q   <= wait_cnt_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_master_arbiter
// Directed bench for bus_master_arbiter. u_dut (TimeoutCycles=64) covers read,
// contention, busy stretch, same-address writes and reset in WAIT; u_to
// (TimeoutCycles=16) covers the timeout abort.
// -----------------------------------------------------------------------------
module tb_bus_master_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req, to_req;
    logic [1:0]  we;
    logic [7:0]  we_ram;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [31:0] bus_data;
    logic        busy, to_busy;

    logic [1:0]  ack, to_ack;
    logic        err, to_err;
    logic [31:0] rdata, to_rdata;
    logic        bwe, to_bwe;
    logic [3:0]  bweram, to_bweram;
    logic [31:0] baddr, to_baddr;
    logic [31:0] bdata, to_bdata;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;

    bus_master_arbiter #(
        .NumRequesters (2),
        .TimeoutCycles (64)
    ) u_dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .req_i         (req),
        .req_we_i      (we),
        .req_we_ram_i  (we_ram),
        .req_address_i (addr),
        .req_data_i    (wdata),
        .ack_o         (ack),
        .error_o       (err),
        .rdata_o       (rdata),
        .bus_we_o      (bwe),
        .bus_we_ram_o  (bweram),
        .bus_address_o (baddr),
        .bus_data_o    (bdata),
        .bus_data_i    (bus_data),
        .bus_busy_i    (busy)
    );

    bus_master_arbiter #(
        .NumRequesters (2),
        .TimeoutCycles (16)
    ) u_to (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .req_i         (to_req),
        .req_we_i      (we),
        .req_we_ram_i  (we_ram),
        .req_address_i (addr),
        .req_data_i    (wdata),
        .ack_o         (to_ack),
        .error_o       (to_err),
        .rdata_o       (to_rdata),
        .bus_we_o      (to_bwe),
        .bus_we_ram_o  (to_bweram),
        .bus_address_o (to_baddr),
        .bus_data_o    (to_bdata),
        .bus_data_i    (bus_data),
        .bus_busy_i    (to_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until ack on u_dut (bounded); n is the number of edges taken.
    task automatic wait_ack(input string tag, output logic [1:0] a, output int n);
        a = '0;
        n = 0;
        while (a == 2'b00 && n < 60) begin
            tick();
            n++;
            a = ack;
        end
        total++;
        assert (a != 2'b00) else begin
            bad++;
            $error("FAIL %s: observed=no ack after %0d cycles expected=ack", tag, n);
        end
    endtask

    task automatic wait_to_ack(input string tag, output logic [1:0] a, output int n);
        a = '0;
        n = 0;
        while (a == 2'b00 && n < 60) begin
            tick();
            n++;
            a = to_ack;
        end
        total++;
        assert (a != 2'b00) else begin
            bad++;
            $error("FAIL %s: observed=no ack after %0d cycles expected=ack", tag, n);
        end
    endtask

    logic [1:0] a;
    int         n;
    logic [1:0] seen;
    logic [1:0] exp_g [4];

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        to_req   = '0;
        we       = '0;
        we_ram   = '0;
        addr     = '0;
        wdata    = '0;
        bus_data = '0;
        busy     = 1'b0;
        to_busy  = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_ack",    64'(ack),    64'h0);
        check("rst_err",    64'(err),    64'h0);
        check("rst_rdata",  64'(rdata),  64'h0);
        check("rst_baddr",  64'(baddr),  64'(IDLE_A));
        check("rst_bwe",    64'(bwe),    64'h0);
        check("rst_bdata",  64'(bdata),  64'h0);
        check("rst_to_baddr", 64'(to_baddr), 64'(IDLE_A));
        rst_n = 1'b1;
        tick();

        // Single read from requester 0 at 0x100
        addr[31:0] = 32'h0000_0100;
        addr[63:32] = 32'h0000_0180;
        bus_data   = 32'hA5A5_A5A5;
        req        = 2'b01;
        tick();
        check("rd_issue_addr", 64'(baddr), 64'h100);
        check("rd_issue_we",   64'(bwe),   64'h0);
        tick();
        check("rd_wait_addr",  64'(baddr), 64'h100);
        check("rd_wait_ack",   64'(ack),   64'h0);
        tick();
        check("rd_early_ack",  64'(ack),   64'h0);
        tick();
        check("rd_ack",   64'(ack),   64'h1);
        check("rd_rdata", 64'(rdata), 64'hA5A5_A5A5);
        check("rd_err",   64'(err),   64'h0);
        check("rd_done_addr", 64'(baddr), 64'(IDLE_A));
        req = 2'b00;
        tick();
        check("rd_after_ack",   64'(ack),   64'h0);
        check("rd_after_rdata", 64'(rdata), 64'h0);
        check("rd_after_addr",  64'(baddr), 64'(IDLE_A));

        // Contention: last grant was 0, so requester 1 leads and they alternate
        exp_g[0] = 2'b10;
        exp_g[1] = 2'b01;
        exp_g[2] = 2'b10;
        exp_g[3] = 2'b01;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ack("ct_wait", a, n);
            check($sformatf("ct_grant%0d", i), 64'(a), 64'(exp_g[i]));
            check($sformatf("ct_lat%0d", i), 64'(n), (i == 0) ? 64'd4 : 64'd5);
        end
        req = 2'b00;
        tick();

        // Busy stretch: 20 busy cycles after ISSUE, ack one edge after busy drops
        bus_data = 32'h1234_5678;
        busy     = 1'b1;
        req      = 2'b01;
        tick();
        check("bs_issue_addr", 64'(baddr), 64'h100);
        repeat (20) tick();
        check("bs_ack_busy", 64'(ack),   64'h0);
        check("bs_addr_busy", 64'(baddr), 64'h100);
        busy = 1'b0;
        tick();
        check("bs_ack",   64'(ack),   64'h1);
        check("bs_rdata", 64'(rdata), 64'h1234_5678);
        check("bs_err",   64'(err),   64'h0);
        req = 2'b00;
        tick();

        // Timeout on u_to: ISSUE edge + 16 WAIT edges + DONE edge
        bus_data = 32'hDEAD_BEEF;
        to_busy  = 1'b1;
        to_req   = 2'b01;
        wait_to_ack("to_wait", a, n);
        check("to_ack",   64'(a),        64'h1);
        check("to_lat",   64'(n),        64'd18);
        check("to_err",   64'(to_err),   64'h1);
        check("to_rdata", 64'(to_rdata), 64'h0);
        to_req  = 2'b00;
        to_busy = 1'b0;
        tick();
        check("to_after_err", 64'(to_err), 64'h0);
        to_req = 2'b10;
        wait_to_ack("to_next_wait", a, n);
        check("to_next_ack",   64'(a),        64'h2);
        check("to_next_lat",   64'(n),        64'd4);
        check("to_next_err",   64'(to_err),   64'h0);
        check("to_next_rdata", 64'(to_rdata), 64'hDEAD_BEEF);
        to_req = 2'b00;
        tick();

        // Two writes to the same address from requester 1
        we           = 2'b10;
        we_ram[7:4]  = 4'hF;
        addr[63:32]  = 32'h0000_0200;
        wdata[63:32] = 32'hCAFE_0001;
        req          = 2'b10;
        tick();
        check("wr1_we",    64'(bwe),    64'h1);
        check("wr1_addr",  64'(baddr),  64'h200);
        check("wr1_weram", 64'(bweram), 64'hF);
        check("wr1_data",  64'(bdata),  64'hCAFE_0001);
        tick();
        check("wr1_wait_we",   64'(bwe),    64'h0);
        check("wr1_wait_data", 64'(bdata),  64'h0);
        check("wr1_wait_addr", 64'(baddr),  64'h200);
        repeat (2) tick();
        check("wr1_ack",       64'(ack),   64'h2);
        check("wr1_done_addr", 64'(baddr), 64'(IDLE_A));
        req = 2'b00;
        tick();
        check("wr_gap_addr", 64'(baddr), 64'(IDLE_A));
        wdata[63:32] = 32'hCAFE_0002;
        req          = 2'b10;
        tick();
        check("wr2_we",   64'(bwe),   64'h1);
        check("wr2_addr", 64'(baddr), 64'h200);
        check("wr2_data", 64'(bdata), 64'hCAFE_0002);
        repeat (3) tick();
        check("wr2_ack", 64'(ack), 64'h2);
        req = 2'b00;
        we  = '0;
        tick();

        // Reset asserted in the third WAIT cycle
        busy = 1'b1;
        req  = 2'b01;
        repeat (4) tick();
        check("rw_wait_addr", 64'(baddr), 64'h100);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_rst_addr", 64'(baddr), 64'(IDLE_A));
        check("rw_rst_ack",  64'(ack),   64'h0);
        check("rw_rst_we",   64'(bwe),   64'h0);
        req  = 2'b00;
        busy = 1'b0;
        #1;
        rst_n = 1'b1;
        seen  = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | ack;
        end
        check("rw_no_ack", 64'(seen), 64'h0);
        req = 2'b11;
        wait_ack("rw_first_wait", a, n);
        check("rw_first_grant", 64'(a), 64'h1);
        req = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
